mac_tx_sched: RTL and testbench

- Egress scheduler between N per-priority output queues (each a pointer FIFO plus a byte-wide data FIFO) and one MAC transmit block.
- Presents a single pointer-FIFO/data-FIFO read interface to the MAC.
- Selects one queue per frame, either by strict priority or by round-robin.
- Holds the selected queue until every byte of the frame has been read by the MAC, so frames never interleave.

---
 rtl/mac_tx_sched.sv | 162 ++++++++++++++++
 tb/tb_mac_tx_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_sched.sv
// mac_tx_sched: egress scheduler that merges NQ per-priority pointer/data
// FIFO pairs into a single pointer/data FIFO read interface for the MAC.
// One queue is selected per frame (strict priority or round-robin) and the
// grant is held until the whole frame has been read, so frames never
// interleave.
//
// Handshake with the MAC (FIFO style): mac_ptr_empty low means mac_ptr_dout
// holds a valid pointer word; a mac_ptr_rd pulse while it is low consumes
// the word (mac_ptr_empty rises on the next edge, mac_ptr_dout stays held).
// Each mac_data_rd while bytes remain consumes one byte, which appears on
// mac_data_dout one cycle later. Reads with nothing to consume are dropped
// (and data over-reads are flagged in err_overread).
module mac_tx_sched #(
  parameter int NQ      = 4,
  parameter bit SP_MODE = 1'b1,
  parameter int DELAY   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NQ-1:0]     q_en,
  input  logic [NQ-1:0]     q_ptr_empty,
  input  logic [16*NQ-1:0]  q_ptr_dout,
  output logic [NQ-1:0]     q_ptr_rd,
  input  logic [8*NQ-1:0]   q_data_dout,
  output logic [NQ-1:0]     q_data_rd,
  output logic              mac_ptr_empty,
  output logic [15:0]       mac_ptr_dout,
  input  logic              mac_ptr_rd,
  input  logic              mac_data_rd,
  output logic [7:0]        mac_data_dout,
  output logic [NQ-1:0]     grant,
  output logic              err_overread,
  output logic [2:0]        state_dbg
);

  localparam int IW = (NQ > 1) ? $clog2(NQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_OFFER = 3'd3;
  localparam logic [2:0] S_XFER  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  // DELAY was a delta-ordering aid in the original behavioural model; the
  // logic here is zero-delay, so the parameter is only range-checked.
  if (NQ < 2 || NQ > 8 || DELAY < 0) begin : g_param_check
    $error("mac_tx_sched: NQ must be 2..8 and DELAY must be non-negative");
  end

  logic [2:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel_idx;
  logic [10:0]   cnt;

  logic [NQ-1:0] req;
  logic [IW-1:0] base_idx;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [NQ-1:0] win_onehot;
  logic [15:0]   ptr_word;
  logic          xfer_rd;

  assign req        = q_en & ~q_ptr_empty;
  assign base_idx   = SP_MODE ? '0 : rr_ptr;
  assign win_onehot = NQ'(1) << win_idx;
  assign state_dbg  = state;

  // Arbiter: first requesting queue searched upward from base_idx, wrapping.
  always_comb begin : p_arb
    int            j;
    logic [IW-1:0] cand;
    j         = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NQ; k++) begin
      j = int'(base_idx) + k;
      if (j >= NQ) j = j - NQ;
      cand = IW'(j);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Datapath muxes driven from the registered queue select, so the last
  // byte (one cycle behind its read strobe) still comes from the granted
  // queue during DRAIN.
  assign ptr_word      = q_ptr_dout[16*sel_idx +: 16];
  assign mac_data_dout = (grant != '0) ? q_data_dout[8*sel_idx +: 8] : 8'h00;

  // Data reads are forwarded only while the frame still has bytes left.
  assign xfer_rd   = (state == S_XFER) && mac_data_rd && (cnt != 11'd0);
  assign q_data_rd = {NQ{xfer_rd}} & grant;

  // Frame sequencing: arbitrate, fetch the pointer, offer it, stream bytes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      grant         <= '0;
      sel_idx       <= '0;
      rr_ptr        <= '0;
      q_ptr_rd      <= '0;
      mac_ptr_empty <= 1'b1;
      mac_ptr_dout  <= 16'h0000;
      cnt           <= 11'd0;
    end else begin
      q_ptr_rd <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant    <= win_onehot;
            sel_idx  <= win_idx;
            q_ptr_rd <= win_onehot;
            rr_ptr   <= (win_idx == IW'(NQ - 1)) ? '0 : win_idx + 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // pointer FIFO sees its read strobe this cycle; data next cycle
          state <= S_LOAD;
        end
        S_LOAD: begin
          mac_ptr_dout  <= ptr_word;
          cnt           <= ptr_word[10:0];
          mac_ptr_empty <= 1'b0;
          state         <= S_OFFER;
        end
        S_OFFER: begin
          // mac_ptr_dout is deliberately held: the MAC samples it late
          if (mac_ptr_rd) begin
            mac_ptr_empty <= 1'b1;
            state         <= (cnt == 11'd0) ? S_DRAIN : S_XFER;
          end
        end
        S_XFER: begin
          if (xfer_rd) begin
            cnt <= cnt - 11'd1;
            if (cnt == 11'd1) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          grant <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky flag for data reads issued when no frame bytes remain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_overread <= 1'b0;
    end else if (mac_data_rd && (cnt == 11'd0)) begin
      err_overread <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_tx_sched.sv
// tb_mac_tx_sched: directed bench for mac_tx_sched. Instance 0 runs strict
// priority, instance 1 round-robin; each has its own behavioural pointer
// and data FIFOs (1-cycle read latency) and a MAC-side driver.
module tb_mac_tx_sched;
  localparam int NQ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring (index 0 = SP, 1 = RR) ----------------
  logic [NQ-1:0]    en   [2];
  logic [NQ-1:0]    pe   [2];
  logic [16*NQ-1:0] pd   [2] = '{default: '0};
  logic [NQ-1:0]    prd  [2];
  logic [8*NQ-1:0]  dd   [2] = '{default: '0};
  logic [NQ-1:0]    drd  [2];
  logic             mpe  [2];
  logic [15:0]      mpd  [2];
  logic             mprd [2];
  logic             mdrd [2];
  logic [7:0]       mdd  [2];
  logic [NQ-1:0]    gnt  [2];
  logic             err  [2];
  logic [2:0]       st   [2];

  mac_tx_sched #(.NQ(NQ), .SP_MODE(1'b1), .DELAY(2)) u_sp (
    .clk(clk), .rstn(rstn), .q_en(en[0]), .q_ptr_empty(pe[0]),
    .q_ptr_dout(pd[0]), .q_ptr_rd(prd[0]), .q_data_dout(dd[0]),
    .q_data_rd(drd[0]), .mac_ptr_empty(mpe[0]), .mac_ptr_dout(mpd[0]),
    .mac_ptr_rd(mprd[0]), .mac_data_rd(mdrd[0]), .mac_data_dout(mdd[0]),
    .grant(gnt[0]), .err_overread(err[0]), .state_dbg(st[0])
  );

  mac_tx_sched #(.NQ(NQ), .SP_MODE(1'b0), .DELAY(2)) u_rr (
    .clk(clk), .rstn(rstn), .q_en(en[1]), .q_ptr_empty(pe[1]),
    .q_ptr_dout(pd[1]), .q_ptr_rd(prd[1]), .q_data_dout(dd[1]),
    .q_data_rd(drd[1]), .mac_ptr_empty(mpe[1]), .mac_ptr_dout(mpd[1]),
    .mac_ptr_rd(mprd[1]), .mac_data_rd(mdrd[1]), .mac_data_dout(mdd[1]),
    .grant(gnt[1]), .err_overread(err[1]), .state_dbg(st[1])
  );

  // ---------------- FIFO models ----------------
  logic [15:0] pmem    [2][NQ][4];
  int          phead   [2][NQ] = '{default: 0};
  int          ptail   [2][NQ] = '{default: 0};
  int          dcnt    [2][NQ] = '{default: 0};
  int          exp_idx [2][NQ] = '{default: 0};
  int          stray = 0;

  function automatic logic [7:0] pat(input int q, input int i);
    int v;
    v = q * 37 + i * 13 + 5;
    return v[7:0];
  endfunction

  always_comb begin
    pe[0] = '0;
    pe[1] = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NQ; i++)
        pe[k][i] = (ptail[k][i] == phead[k][i]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NQ; i++) begin
        if (prd[k][i]) begin
          pd[k][16*i +: 16] <= pmem[k][i][phead[k][i] % 4];
          phead[k][i]       <= phead[k][i] + 1;
          if (phead[k][i] == ptail[k][i]) stray <= stray + 1;
        end
        if (drd[k][i]) begin
          dd[k][8*i +: 8] <= pat(i, dcnt[k][i]);
          dcnt[k][i]      <= dcnt[k][i] + 1;
        end
        if ((prd[k][i] || drd[k][i]) && !gnt[k][i]) stray <= stray + 1;
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input int k, input int q, input logic [15:0] w);
    pmem[k][q][ptail[k][q] % 4] = w;
    ptail[k][q] = ptail[k][q] + 1;
  endtask

  // Take one whole frame from instance k, expected from queue q with
  // pointer word w; extra!=0 adds one data read during the drain cycle.
  task automatic serve(input int k, input int q, input logic [15:0] w, input int extra);
    int t, len, bad, d0;
    len = int'(w[10:0]);
    t = 0;
    while (mpe[k] !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ptr_offer_timeout", 32'(t < 40), 32'd1);
    chk("grant_onehot", 32'(gnt[k]), 32'(1 << q));
    chk("mac_ptr_dout", 32'(mpd[k]), 32'(w));
    d0 = dcnt[k][q];
    mprd[k] = 1'b1;
    @(negedge clk);
    mprd[k] = 1'b0;
    chk("ptr_empty_after_rd", 32'(mpe[k]), 32'd1);
    chk("ptr_dout_held", 32'(mpd[k]), 32'(w));
    bad = 0;
    for (int b = 0; b < len; b++) begin
      mdrd[k] = 1'b1;
      @(negedge clk);
      mdrd[k] = 1'b0;
      if (mdd[k] !== pat(q, exp_idx[k][q])) bad++;
      exp_idx[k][q]++;
    end
    chk("frame_bytes_bad", 32'(bad), 32'd0);
    if (extra != 0) mdrd[k] = 1'b1;
    @(negedge clk);
    mdrd[k] = 1'b0;
    chk("data_rd_count", 32'(dcnt[k][q] - d0), 32'(len));
    chk("grant_release", 32'(gnt[k]), 32'd0);
    chk("idle_data_zero", 32'(mdd[k]), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t, d0, bad;
    for (int k = 0; k < 2; k++) begin
      en[k]   = '1;
      mprd[k] = 1'b0;
      mdrd[k] = 1'b0;
    end
    repeat (2) @(negedge clk);

    // reset values
    for (int k = 0; k < 2; k++) begin
      chk("rst_q_ptr_rd", 32'(prd[k]), 32'd0);
      chk("rst_q_data_rd", 32'(drd[k]), 32'd0);
      chk("rst_grant", 32'(gnt[k]), 32'd0);
      chk("rst_ptr_empty", 32'(mpe[k]), 32'd1);
      chk("rst_ptr_dout", 32'(mpd[k]), 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // pointer read while nothing is offered is ignored
    mprd[0] = 1'b1;
    @(negedge clk);
    mprd[0] = 1'b0;
    @(negedge clk);
    chk("ptr_rd_ignored_empty", 32'(mpe[0]), 32'd1);
    chk("ptr_rd_ignored_grant", 32'(gnt[0]), 32'd0);

    // single 64-byte frame on queue 1, with pointer latency
    push(0, 1, 16'h0040);
    @(negedge clk);
    chk("t1_ptr_rd_pulse", 32'(prd[0]), 32'h2);
    chk("t1_grant", 32'(gnt[0]), 32'h2);
    @(negedge clk);
    chk("t1_ptr_rd_single", 32'(prd[0]), 32'd0);
    chk("t1_empty_fetch", 32'(mpe[0]), 32'd1);
    @(negedge clk);
    chk("t1_empty_load", 32'(mpe[0]), 32'd0);
    chk("t1_ptr_dout", 32'(mpd[0]), 32'h0040);
    serve(0, 1, 16'h0040, 0);

    // strict priority: queue 0 before queue 2
    push(0, 2, 16'h1003);
    push(0, 0, 16'h2004);
    serve(0, 0, 16'h2004, 0);
    serve(0, 2, 16'h1003, 0);

    // maximum length, all upper pointer bits set
    push(0, 1, 16'hFFFF);
    serve(0, 1, 16'hFFFF, 0);

    // zero-length frame
    push(0, 3, 16'h5800);
    serve(0, 3, 16'h5800, 0);
    chk("zero_len_no_err", 32'(err[0]), 32'd0);

    // over-read: 5-byte frame, 6 MAC reads
    push(0, 3, 16'h0005);
    serve(0, 3, 16'h0005, 1);
    chk("overread_err", 32'(err[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("overread_sticky", 32'(err[0]), 32'd1);

    // round-robin: two frames per queue
    push(1, 0, 16'h0003); push(1, 0, 16'h0802);
    push(1, 1, 16'h0001); push(1, 1, 16'h0004);
    push(1, 2, 16'h0002); push(1, 2, 16'h3064);
    push(1, 3, 16'h0003); push(1, 3, 16'h0001);
    serve(1, 0, 16'h0003, 0);
    serve(1, 1, 16'h0001, 0);
    serve(1, 2, 16'h0002, 0);
    serve(1, 3, 16'h0003, 0);
    en[1] = 4'b1011;
    serve(1, 0, 16'h0802, 0);
    serve(1, 1, 16'h0004, 0);
    serve(1, 3, 16'h0001, 0);
    repeat (5) @(negedge clk);
    chk("rr_disabled_not_granted", 32'(gnt[1]), 32'd0);

    // re-enable queue 2: its 100-byte frame, then reset after 10 bytes
    en[1] = 4'hF;
    t = 0;
    while (mpe[1] !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("rst_test_offer_timeout", 32'(t < 40), 32'd1);
    chk("rst_test_grant", 32'(gnt[1]), 32'h4);
    chk("rst_test_ptr_dout", 32'(mpd[1]), 32'h3064);
    mprd[1] = 1'b1;
    @(negedge clk);
    mprd[1] = 1'b0;
    en[1] = 4'b1011;  // disabling the granted queue must not stall the frame
    d0 = dcnt[1][2];
    bad = 0;
    for (int b = 0; b < 10; b++) begin
      mdrd[1] = 1'b1;
      @(negedge clk);
      mdrd[1] = 1'b0;
      if (mdd[1] !== pat(2, exp_idx[1][2])) bad++;
      exp_idx[1][2]++;
    end
    chk("rst_test_bytes_bad", 32'(bad), 32'd0);
    chk("rst_test_rd_count", 32'(dcnt[1][2] - d0), 32'd10);
    chk("rst_test_grant_held", 32'(gnt[1]), 32'h4);
    mdrd[1] = 1'b1;
    rstn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(gnt[1]), 32'd0);
    chk("async_rst_ptr_empty", 32'(mpe[1]), 32'd1);
    chk("async_rst_ptr_dout", 32'(mpd[1]), 32'd0);
    chk("async_rst_q_ptr_rd", 32'(prd[1]), 32'd0);
    chk("async_rst_q_data_rd", 32'(drd[1]), 32'd0);
    chk("async_rst_data_dout", 32'(mdd[1]), 32'd0);
    chk("async_rst_err_sp", 32'(err[0]), 32'd0);
    mdrd[1] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    en[1] = 4'hF;

    // after reset the round-robin pointer restarts at 0: queue 1 before 3
    push(1, 3, 16'h0002);
    push(1, 1, 16'h0001);
    serve(1, 1, 16'h0001, 0);
    serve(1, 3, 16'h0002, 0);
    chk("rr_no_err", 32'(err[1]), 32'd0);

    chk("stray_fifo_reads", 32'(stray), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
